fetch_unit: RTL and testbench

- Instruction-fetch stage for the RV32 core. It sits directly upstream of the dual-port memory's instruction port.
- Owns the PC, drives imem_en and imem_addr, and consumes imem_data, which has 1-cycle synchronous-read latency and holds its value while imem_en=0.
- Presents fetched instructions to decode with a valid/ready handshake and accepts branch/jump redirects from execute.

---
 rtl/core_pkg.sv | 19 +
 rtl/fetch_unit.sv | 83 ++++++++
 tb/tb_fetch_unit.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/core_pkg.sv
// Shared core definitions: word width, instruction type, fetch FSM states
// and the reset defaults used by the fetch stage.
package core_pkg;

  localparam int XLEN = 32;

  typedef logic [XLEN-1:0] instr_t;

  // Defaults for fetch_unit parameters: boot address and the addi x0,x0,0 filler.
  localparam logic [XLEN-1:0] RESET_PC_DEF  = 32'h0000_0000;
  localparam instr_t          NOP_INSTR_DEF = 32'h0000_0013;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, drives the instruction-memory read
// port and hands words to decode over a valid/ready handshake. Because the
// memory holds its read data while imem_en=0, a stalled instruction simply
// stays on imem_data and no skid buffer is needed.
module fetch_unit
  import core_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEF,
  parameter instr_t          NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_en,
  output logic [XLEN-1:0] imem_addr,
  input  instr_t          imem_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output instr_t          out_instr,
  output logic [XLEN-1:0] out_pc
);

  localparam logic [XLEN-1:0] ALIGN_MASK = ~32'd3;

  logic [XLEN-1:0] pc_f_q, pc_f_d;       // next address to request
  logic [XLEN-1:0] pc_d_q, pc_d_d;       // address whose word is on imem_data
  logic            valid_d_q, valid_d_d; // imem_data holds a live word
  fetch_state_t    state_q, state_d;

  logic            stall;
  logic [XLEN-1:0] fetch_addr;

  // Request address, enable and decode-side outputs; reset forces the idle view.
  always_comb begin
    stall      = valid_d_q & ~out_ready;
    fetch_addr = redirect_valid ? (redirect_pc & ALIGN_MASK) : pc_f_q;
    imem_en    = ~reset & (redirect_valid | ~stall);
    imem_addr  = reset ? (RESET_PC & ALIGN_MASK) : fetch_addr;
    out_valid  = ~reset & valid_d_q & ~redirect_valid;
    out_instr  = out_valid ? imem_data : NOP_INSTR;
    out_pc     = reset ? (RESET_PC & ALIGN_MASK) : pc_d_q;
  end

  // PC advance: every enabled request moves the pipeline by one word (modular wrap).
  always_comb begin
    pc_f_d    = pc_f_q;
    pc_d_d    = pc_d_q;
    valid_d_d = valid_d_q;
    if (imem_en) begin
      pc_d_d    = imem_addr;
      pc_f_d    = imem_addr + 32'd4;
      valid_d_d = 1'b1;
    end
  end

  // FSM next state: BOOT issues the first fetch, HOLD tracks a decode stall.
  always_comb begin
    state_d = state_q;
    case (state_q)
      BOOT:    state_d = RUN;
      RUN:     if (stall && !redirect_valid) state_d = HOLD;
      HOLD:    if (out_ready || redirect_valid) state_d = RUN;
      default: state_d = BOOT;
    endcase
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_f_q    <= RESET_PC & ALIGN_MASK;
      pc_d_q    <= RESET_PC & ALIGN_MASK;
      valid_d_q <= 1'b0;
      state_q   <= BOOT;
    end else begin
      pc_f_q    <= pc_f_d;
      pc_d_q    <= pc_d_d;
      valid_d_q <= valid_d_d;
      state_q   <= state_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: synchronous-read memory model, scoreboard of the
// (pc, instr) pairs decode must accept, plus cycle-exact directed checks.
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_en;
  logic [31:0] imem_addr;
  logic [31:0] imem_data = 32'h0;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  fetch_unit dut (
    .clk            (clk),
    .reset          (reset),
    .imem_en        (imem_en),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memval(input logic [31:0] a);
    case (a)
      32'h0:   return 32'h0000_0011;
      32'h4:   return 32'h0000_0022;
      32'h8:   return 32'h0000_0033;
      32'hC:   return 32'h0000_0044;
      default: return a ^ 32'hC0DE_0000;
    endcase
  endfunction

  // Instruction memory: 1-cycle synchronous read, output held while disabled.
  always @(posedge clk) if (imem_en) imem_data <= memval(imem_addr);

  task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every accepted instruction must be the next expected pc.
  always @(negedge clk) begin
    if (!out_valid) begin
      chk_eq("nop_fill", out_instr, NOP);
    end else if (out_ready) begin
      if (exp_q.size() == 0) begin
        chk_eq("sb_unexpected_pc", out_pc, 32'hDEAD_BEEF);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        chk_eq("sb_pc", out_pc, e);
        chk_eq("sb_instr", out_instr, memval(e));
      end
    end
  end

  initial begin
    reset = 1'b1; out_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0;
    repeat (3) tick();
    @(negedge clk);
    chk_eq("rst_en", imem_en, 0);
    chk_eq("rst_valid", out_valid, 0);
    chk_eq("rst_instr", out_instr, NOP);
    chk_eq("rst_pc", out_pc, 0);
    chk_eq("rst_addr", imem_addr, 0);

    // Boot and straight-line stream
    exp_q.push_back(32'h0); exp_q.push_back(32'h4);
    exp_q.push_back(32'h8); exp_q.push_back(32'hC);
    tick(); reset = 1'b0;
    @(negedge clk);
    chk_eq("boot_en", imem_en, 1);
    chk_eq("boot_addr", imem_addr, 0);
    chk_eq("boot_valid", out_valid, 0);
    tick();
    @(negedge clk);
    chk_eq("lat_valid", out_valid, 1);
    chk_eq("lat_pc", out_pc, 0);
    tick();                      // pc 4 at decode
    tick(); out_ready = 1'b0;    // pc 8 at decode, stalled
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_eq("stall_en", imem_en, 0);
      chk_eq("stall_valid", out_valid, 1);
      chk_eq("stall_pc", out_pc, 32'h8);
      chk_eq("stall_instr", out_instr, 32'h33);
      tick();
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk_eq("release_pc", out_pc, 32'h8);
    tick();
    @(negedge clk);
    chk_eq("nogap_valid", out_valid, 1);
    chk_eq("nogap_pc", out_pc, 32'hC);

    // Single-cycle reset pulse mid-stream
    exp_q.push_back(32'h10);
    tick();                      // 0x10 accepted
    tick(); reset = 1'b1;
    @(negedge clk);
    chk_eq("midrst_valid", out_valid, 0);
    chk_eq("midrst_en", imem_en, 0);
    exp_q.push_back(32'h0);
    tick(); reset = 1'b0;
    @(negedge clk);
    chk_eq("reboot_valid", out_valid, 0);
    chk_eq("reboot_addr", imem_addr, 0);
    tick();
    @(negedge clk);
    chk_eq("relat_valid", out_valid, 1);
    chk_eq("relat_pc", out_pc, 0);

    // Redirect while pc 4 is at decode
    tick(); redirect_valid = 1'b1; redirect_pc = 32'h100;
    @(negedge clk);
    chk_eq("rd_valid", out_valid, 0);
    chk_eq("rd_addr", imem_addr, 32'h100);
    chk_eq("rd_en", imem_en, 1);
    exp_q.push_back(32'h100); exp_q.push_back(32'h104);
    tick(); redirect_valid = 1'b0;
    @(negedge clk);
    chk_eq("rd_tgt_pc", out_pc, 32'h100);
    chk_eq("rd_tgt_instr", out_instr, memval(32'h100));
    tick();                      // 0x104

    // Redirect during HOLD with a misaligned target
    tick(); out_ready = 1'b0;    // 0x108 stalled
    tick(); redirect_valid = 1'b1; redirect_pc = 32'h203;
    @(negedge clk);
    chk_eq("hold_rd_addr", imem_addr, 32'h200);
    chk_eq("hold_rd_en", imem_en, 1);
    chk_eq("hold_rd_valid", out_valid, 0);
    exp_q.push_back(32'h200);
    tick(); redirect_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk_eq("hold_tgt_pc", out_pc, 32'h200);

    // Redirect to the top word and wrap to zero
    tick(); redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    exp_q.push_back(32'hFFFF_FFFC); exp_q.push_back(32'h0);
    tick(); redirect_valid = 1'b0;
    @(negedge clk);
    chk_eq("wrap_hi_pc", out_pc, 32'hFFFF_FFFC);
    tick();
    @(negedge clk);
    chk_eq("wrap_lo_pc", out_pc, 32'h0);

    // Back-to-back redirects: only the last target issues
    tick(); redirect_valid = 1'b1; redirect_pc = 32'h300;
    tick(); redirect_pc = 32'h400;
    @(negedge clk);
    chk_eq("b2b_valid", out_valid, 0);
    chk_eq("b2b_addr", imem_addr, 32'h400);
    exp_q.push_back(32'h400);
    tick(); redirect_valid = 1'b0;
    @(negedge clk);
    chk_eq("b2b_pc", out_pc, 32'h400);

    // Reset during HOLD, then a redirect in the BOOT cycle
    tick(); out_ready = 1'b0;    // 0x404 held
    tick(); reset = 1'b1;
    @(negedge clk);
    chk_eq("holdrst_valid", out_valid, 0);
    tick(); reset = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h500;
    @(negedge clk);
    chk_eq("boot_rd_addr", imem_addr, 32'h500);
    chk_eq("boot_rd_en", imem_en, 1);
    exp_q.push_back(32'h500);
    tick(); redirect_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk_eq("boot_rd_pc", out_pc, 32'h500);
    tick(); out_ready = 1'b0;
    tick();
    chk_eq("sb_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
